mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_access_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Data-memory request/acknowledge bus between the MEM stage and dmem.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store sequencer with alignment check and ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_load,
    input  logic              mem_store,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign_ext,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              wb_ready,
    output logic              mem_stall,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              mem_addr_err,
    output logic              mem_bus_err,
    mem_access_unit_if.master dmem
);

    localparam logic [7:0] c_timeout = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        load_q, load_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        bus_err_q, bus_err_d;

    logic        w_access;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_timeout;

    always_comb begin
        w_access = mem_valid & (mem_load | mem_store);
        case (mem_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~mem_addr[0];
            2'b10:   w_aligned = (mem_addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase

        // Loads always fetch the whole word; lane selection happens on return.
        case (mem_size)
            2'b00:   w_be = 4'b0001 << mem_addr[1:0];
            2'b01:   w_be = mem_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
        if (mem_load) begin
            w_be = 4'b1111;
        end

        case (mem_size)
            2'b00:   w_wdata = {4{mem_wdata[7:0]}};
            2'b01:   w_wdata = {2{mem_wdata[15:0]}};
            default: w_wdata = mem_wdata;
        endcase

        case (lane_q)
            2'd0:    w_byte = dmem.dmem_rdata[7:0];
            2'd1:    w_byte = dmem.dmem_rdata[15:8];
            2'd2:    w_byte = dmem.dmem_rdata[23:16];
            default: w_byte = dmem.dmem_rdata[31:24];
        endcase
        w_half = lane_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

        case (size_q)
            2'b00:   w_load_data = {{24{sign_q & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{sign_q & w_half[15]}}, w_half};
            default: w_load_data = dmem.dmem_rdata;
        endcase

        w_timeout = ((cnt_q + 8'd1) == c_timeout);
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        lane_d       = lane_q;
        size_d       = size_q;
        sign_d       = sign_q;
        load_d       = load_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        done_d       = done_q;
        bus_err_d    = bus_err_q;
        mem_stall    = 1'b0;
        mem_addr_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_access && w_aligned) begin
                    mem_stall    = 1'b1;
                    state_d      = S_REQ;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = mem_store;
                    dmem_addr_d  = {mem_addr[31:2], 2'b00};
                    dmem_wdata_d = w_wdata;
                    dmem_be_d    = w_be;
                    lane_d       = mem_addr[1:0];
                    size_d       = mem_size;
                    sign_d       = mem_sign_ext;
                    load_d       = mem_load;
                    cnt_d        = 8'd0;
                end else if (w_access) begin
                    mem_addr_err = 1'b1;
                end
            end
            S_REQ: begin
                mem_stall = 1'b1;
                // An ack on the last permitted cycle still wins over the timeout.
                if (dmem.dmem_ack) begin
                    state_d    = S_DONE;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    cnt_d      = 8'd0;
                    rdata_d    = load_q ? w_load_data : 32'd0;
                    done_d     = 1'b1;
                    bus_err_d  = 1'b0;
                end else if (w_timeout) begin
                    state_d    = S_DONE;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    cnt_d      = 8'd0;
                    rdata_d    = 32'd0;
                    done_d     = 1'b1;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                if (wb_ready) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b0;
                    bus_err_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            dmem_be_q    <= 4'd0;
            lane_q       <= 2'd0;
            size_q       <= 2'd0;
            sign_q       <= 1'b0;
            load_q       <= 1'b0;
            cnt_q        <= 8'd0;
            rdata_q      <= 32'd0;
            done_q       <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            load_q       <= load_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dmem.dmem_req   = dmem_req_q;
    assign dmem.dmem_we    = dmem_we_q;
    assign dmem.dmem_addr  = dmem_addr_q;
    assign dmem.dmem_wdata = dmem_wdata_q;
    assign dmem.dmem_be    = dmem_be_q;
    assign mem_rdata       = rdata_q;
    assign mem_done        = done_q;
    assign mem_bus_err     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench: directed vector table, reset/ack corner cases, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int TO = 4;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
        int          wbw;
        logic        e_aerr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        e_berr;
        int          e_cyc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        mem_valid, mem_load, mem_store, mem_sign_ext, wb_ready;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_stall, mem_done, mem_addr_err, mem_bus_err;
    logic [31:0] mem_rdata;

    int          ack_delay;
    int          age;
    logic        force_ack;
    logic [31:0] resp_rdata;
    int          n_vec;
    int          n_err;
    string       tag;

    mem_access_unit_if dm();

    mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_valid    (mem_valid),
        .mem_load     (mem_load),
        .mem_store    (mem_store),
        .mem_size     (mem_size),
        .mem_sign_ext (mem_sign_ext),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .wb_ready     (wb_ready),
        .mem_stall    (mem_stall),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .mem_addr_err (mem_addr_err),
        .mem_bus_err  (mem_bus_err),
        .dmem         (dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack after the request has been up for ack_delay cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset)                          age <= 0;
        else if (dm.dmem_req && !dm.dmem_ack) age <= age + 1;
        else                                 age <= 0;
    end
    always_comb dm.dmem_ack = force_ack | (dm.dmem_req & (age == ack_delay));
    assign dm.dmem_rdata = resp_rdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%s]: got 0x%08h, expected 0x%08h", nm, tag, act, exp);
        end
    endtask

    function automatic logic ref_aligned(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return 1'b1;
            2'd1:    return (a % 2) == 0;
            2'd2:    return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic ld, input logic [1:0] sz, input logic [31:0] a);
        if (ld) return 4'hF;
        case (sz)
            2'd0:    return 4'(1 << (a % 4));
            2'd1:    return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'd0:    return (wd % 256) * 32'h0101_0101;
            2'd1:    return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        case (sz)
            2'd0: begin
                v = (rd >> (8 * (a % 4))) % 256;
                if (sx && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (rd >> (16 * ((a / 2) % 2))) % 65536;
                if (sx && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Entered and left at posedge+1 with the DUT idle.
    task automatic do_access(input vec_t v);
        int  cyc;
        bit  seen;
        mem_valid = 1'b1;  mem_load = v.ld;  mem_store = v.st;
        mem_size = v.sz;   mem_sign_ext = v.sx;
        mem_addr = v.a;    mem_wdata = v.wd;
        ack_delay = v.dly; resp_rdata = v.rd;
        wb_ready = 1'b1;
        @(negedge clk);
        check("stall_accept", mem_stall, !v.e_aerr);
        check("addr_err", mem_addr_err, v.e_aerr);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        mem_load = 1'($urandom_range(0, 1)); mem_store = ~mem_load;
        mem_size = 2'($urandom_range(0, 3)); mem_addr = $urandom; mem_wdata = $urandom;
        mem_sign_ext = 1'($urandom_range(0, 1));
        wb_ready = (v.wbw == 0);
        if (v.e_aerr) begin
            @(negedge clk);
            check("no_req", dm.dmem_req, 0);
            check("no_stall", mem_stall, 0);
            check("no_done", mem_done, 0);
            @(posedge clk); #1;
            return;
        end
        cyc = 0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_done) begin
                seen = 1;
                break;
            end
            cyc++;
            check("req", dm.dmem_req, 1);
            check("we", dm.dmem_we, v.st);
            check("dmem_addr", dm.dmem_addr, v.a & 32'hFFFF_FFFC);
            check("be", dm.dmem_be, v.e_be);
            if (v.st) check("dmem_wdata", dm.dmem_wdata, v.e_wd);
            check("stall_req", mem_stall, 1);
            @(posedge clk); #1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_wait [%s]: mem_done not seen within 300 cycles", tag);
            return;
        end
        check("req_cycles", cyc, v.e_cyc);
        check("rdata", mem_rdata, v.e_rd);
        check("bus_err", mem_bus_err, v.e_berr);
        check("stall_done", mem_stall, 0);
        check("req_done", dm.dmem_req, 0);
        for (int k = 1; k <= v.wbw; k++) begin
            @(posedge clk); #1;
            wb_ready = (k == v.wbw);
            @(negedge clk);
            check("done_held", mem_done, 1);
            check("rdata_held", mem_rdata, v.e_rd);
            check("bus_err_held", mem_bus_err, v.e_berr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("done_clear", mem_done, 0);
        check("bus_err_clear", mem_bus_err, 0);
        @(posedge clk); #1;
    endtask

    vec_t tbl[14];
    vec_t rv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; tag = "reset";
        reset = 1'b0; force_ack = 1'b0; ack_delay = 0; resp_rdata = 32'd0;
        mem_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0; mem_size = 2'd0;
        mem_sign_ext = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; wb_ready = 1'b1;

        //          ld    st    sz     sx    addr          wdata         rdata         dly wbw aerr  be    exp_wdata     exp_rdata     berr  cyc
        tbl[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,  0, 1'b0, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b0, 1};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        32'h8012_3456, 1,  0, 1'b0, 4'hF, 32'h0,        32'hFFFF_FF80, 1'b0, 2};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h8012_3456, 0,  1, 1'b0, 4'hF, 32'h0,        32'h0000_0080, 1'b0, 1};
        tbl[3]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        32'h8012_3456, 2,  0, 1'b0, 4'hF, 32'h0,        32'h0000_8012, 1'b0, 3};
        tbl[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,        32'h8012_3456, 0,  0, 1'b0, 4'hF, 32'h0,        32'hFFFF_8012, 1'b0, 1};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'hFFFF_FFFF, 0,  0, 1'b0, 4'hC, 32'hABCD_ABCD, 32'h0,        1'b0, 1};
        tbl[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'hFFFF_FFFF, 2,  0, 1'b0, 4'h2, 32'hA5A5_A5A5, 32'h0,        1'b0, 3};
        tbl[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'h1122_3344, 32'h0,        3,  0, 1'b0, 4'hF, 32'h1122_3344, 32'h0,        1'b0, 4};
        tbl[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0,        32'h5555_5555, 255, 3, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 4};
        tbl[9]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0108, 32'h0,        32'h1234_5678, 4,  0, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 4};
        tbl[10] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0,  0, 1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 0};
        tbl[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        0,  0, 1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 0};
        tbl[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'h0,        32'h0,        0,  0, 1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 0};
        tbl[13] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_010C, 32'h0,        32'hCAFE_F00D, 0,  2, 1'b0, 4'hF, 32'h0,        32'hCAFE_F00D, 1'b0, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", dm.dmem_req, 0);
        check("rst_we", dm.dmem_we, 0);
        check("rst_be", dm.dmem_be, 0);
        check("rst_addr", dm.dmem_addr, 0);
        check("rst_wdata", dm.dmem_wdata, 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_done", mem_done, 0);
        check("rst_bus_err", mem_bus_err, 0);
        check("rst_stall", mem_stall, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Table vectors; the first one starts on the cycle reset is released.
        for (int i = 0; i < 14; i++) begin
            tag = $sformatf("vec%0d", i);
            do_access(tbl[i]);
        end

        // Reset in the middle of a bus request.
        tag = "reset_mid_req";
        mem_valid = 1'b1; mem_load = 1'b1; mem_store = 1'b0; mem_size = 2'd2;
        mem_addr = 32'h0000_0300; ack_delay = 255; resp_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        #1;
        check("req_before_rst", dm.dmem_req, 1);
        reset = 1'b0;
        #1;
        check("req_async", dm.dmem_req, 0);
        check("be_async", dm.dmem_be, 0);
        check("addr_async", dm.dmem_addr, 0);
        check("rdata_async", mem_rdata, 0);
        check("done_async", mem_done, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_rst", mem_done, 0);
            check("no_req_after_rst", dm.dmem_req, 0);
            @(posedge clk); #1;
        end
        rv = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0304, 32'h0, 32'h0BAD_F00D, 3, 0,
               1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 4};
        do_access(rv);

        // Stray ack while idle must not produce a completion.
        tag = "stray_ack";
        force_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stray_done", mem_done, 0);
            check("stray_stall", mem_stall, 0);
            @(posedge clk); #1;
        end
        force_ack = 1'b0;
        @(negedge clk);
        check("stray_done_after", mem_done, 0);
        @(posedge clk); #1;

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            tag = $sformatf("rand%0d", i);
            rv.ld  = 1'($urandom_range(0, 1));
            rv.st  = ~rv.ld;
            rv.sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rv.sx  = 1'($urandom_range(0, 1));
            rv.a   = $urandom;
            rv.wd  = $urandom;
            rv.rd  = $urandom;
            rv.dly = int'($urandom_range(0, 5));
            rv.wbw = int'($urandom_range(0, 2));
            rv.e_aerr = !ref_aligned(rv.sz, rv.a);
            rv.e_be   = ref_be(rv.ld, rv.sz, rv.a);
            rv.e_wd   = ref_wdata(rv.sz, rv.wd);
            rv.e_berr = (rv.dly >= TO);
            rv.e_cyc  = rv.e_berr ? TO : rv.dly + 1;
            rv.e_rd   = (rv.e_berr || !rv.ld) ? 32'd0 : ref_load(rv.sz, rv.sx, rv.a, rv.rd);
            do_access(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
